// File: rtl/uart_log_arbiter.sv
// Round-robin arbiter sharing one uart_hex_logger between N debug requesters.
// Each requester owns a one-deep value slot; grants drive the logger trigger/busy handshake.
module uart_log_arbiter #(
  parameter int unsigned N            = 4,
  parameter int unsigned W            = 16,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_val,
  input  logic           ovf_clr,
  output logic           log_trigger,
  output logic [W-1:0]   log_val,
  input  logic           log_busy,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  output logic [2:0]     active_id,
  output logic           timeout
);

  localparam int unsigned CW = 8;
  localparam int          NS = int'(N);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      ptr;
  logic [W-1:0]    slot_val [N];
  logic            grant_c;
  logic            to_set_c;
  logic [2:0]      winner_c;
  logic [N-1:0]    gnt_c;
  logic [N-1:0]    ovf_set_c;

  // Winner is the pending slot at the smallest circular distance from ptr.
  always_comb begin
    int best;
    int d;
    winner_c = '0;
    best     = NS;
    for (int i = 0; i < NS; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + NS;
      if (pending[i] && (d < best)) begin
        best     = d;
        winner_c = 3'(i);
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    grant_c  = 1'b0;
    to_set_c = 1'b0;
    case (state)
      IDLE: begin
        if (!log_busy && (|pending)) begin
          grant_c = 1'b1;
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end
      end
      WAIT_BUSY: begin
        if (log_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT)) begin
          to_set_c = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!log_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-slot grant and dropped-request decode.
  always_comb begin
    gnt_c     = '0;
    ovf_set_c = '0;
    for (int i = 0; i < NS; i++) begin
      gnt_c[i]     = grant_c && (winner_c == 3'(i));
      ovf_set_c[i] = req[i] && pending[i] && !gnt_c[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_trigger <= 1'b0;
      log_val     <= '0;
      active_id   <= '0;
      ptr         <= '0;
      pending     <= '0;
      overflow    <= '0;
      timeout     <= 1'b0;
      for (int i = 0; i < NS; i++) slot_val[i] <= '0;
    end else begin
      log_trigger <= grant_c;
      if (grant_c) begin
        active_id <= winner_c;
        ptr       <= (winner_c == 3'(N - 1)) ? 3'd0 : winner_c + 3'd1;
      end
      for (int i = 0; i < NS; i++) begin
        if (gnt_c[i]) log_val <= slot_val[i];
        // A request on the grant edge reloads the slot instead of overflowing.
        if (req[i] && (!pending[i] || gnt_c[i])) begin
          slot_val[i] <= req_val[i*W +: W];
          pending[i]  <= 1'b1;
        end else if (gnt_c[i]) begin
          pending[i] <= 1'b0;
        end
      end
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set_c;
      timeout  <= (timeout & ~ovf_clr) | to_set_c;
    end
  end

endmodule

// File: tb/tb_uart_log_arbiter.sv
// Bench for uart_log_arbiter: vector table, directed corner sequences and a
// randomized run checked against a cycle-level reference model.
module tb_uart_log_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned BT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*W-1:0] req_val;
  logic          ovf_clr;
  logic          log_trigger;
  logic [W-1:0]  log_val;
  logic          log_busy;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;
  logic [2:0]    active_id;
  logic          timeout;
  logic          busy_tab;
  logic          busy_log;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  assign log_busy = busy_tab | busy_log;

  uart_log_arbiter #(.N(N), .W(W), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_val(req_val), .ovf_clr(ovf_clr),
    .log_trigger(log_trigger), .log_val(log_val), .log_busy(log_busy),
    .pending(pending), .overflow(overflow), .active_id(active_id), .timeout(timeout)
  );

  // Logger stand-in: busy rises right after a trigger and holds for lg_len cycles.
  int lg_en  = 0;
  int lg_len = 3;
  int lg_left;
  always @(negedge clk) begin
    if (lg_en == 0) begin
      busy_log <= 1'b0;
      lg_left  <= 0;
    end else if (log_trigger) begin
      busy_log <= 1'b1;
      lg_left  <= lg_len;
    end else if (lg_left > 1) begin
      lg_left <= lg_left - 1;
    end else begin
      busy_log <= 1'b0;
      lg_left  <= 0;
    end
  end

  logic [2:0]  gq_id[$];
  logic [15:0] gq_val[$];
  always @(negedge clk) begin
    if (log_trigger) begin
      gq_id.push_back(active_id);
      gq_val.push_back(log_val);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_req(input logic [3:0] r, input logic [15:0] base, input bit inc);
    req = r;
    for (int i = 0; i < int'(N); i++) req_val[i*16 +: 16] = inc ? base + 16'(i) : base;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_val = '0; ovf_clr = 1'b0; busy_tab = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req; logic [15:0] val; logic busy; logic clr;
    logic trig; logic [15:0] lval; logic [2:0] id; logic [3:0] pend; logic [3:0] ovf;
  } vec_t;
  vec_t tab[29];

  function automatic vec_t mk(logic [3:0] r, logic [15:0] v, logic b, logic c,
                              logic t, logic [15:0] lv, logic [2:0] id, logic [3:0] p, logic [3:0] o);
    vec_t x;
    x.req = r; x.val = v; x.busy = b; x.clr = c;
    x.trig = t; x.lval = lv; x.id = id; x.pend = p; x.ovf = o;
    return x;
  endfunction

  // Reference model state, advanced once per clock from the pre-edge inputs.
  logic [15:0] m_val[4];
  logic [3:0]  m_pend, m_ovf;
  logic        m_trig, m_to;
  logic [15:0] m_lval;
  int          m_id, m_ptr, m_phase, m_wait;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_val[i] = '0;
    m_pend = '0; m_ovf = '0; m_trig = 1'b0; m_to = 1'b0; m_lval = '0;
    m_id = 0; m_ptr = 0; m_phase = 0; m_wait = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [63:0] rv, input logic c, input logic b);
    bit grant;
    int w;
    logic [3:0] ovs;
    grant = (m_phase == 0) && !b && (m_pend != 4'b0);
    w = 0;
    if (grant) begin
      for (int k = int'(N) - 1; k >= 0; k--)
        if (m_pend[(m_ptr + k) % int'(N)]) w = (m_ptr + k) % int'(N);
      m_lval = m_val[w];
      m_id   = w;
      m_ptr  = (w + 1) % int'(N);
    end
    m_trig = grant;
    ovs = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r[i] && (!m_pend[i] || (grant && w == i))) begin
        m_val[i]  = rv[i*16 +: 16];
        m_pend[i] = 1'b1;
      end else if (r[i]) begin
        ovs[i] = 1'b1;
      end else if (grant && w == i) begin
        m_pend[i] = 1'b0;
      end
    end
    if (c) begin m_ovf = '0; m_to = 1'b0; end
    m_ovf = m_ovf | ovs;
    case (m_phase)
      0: if (grant) begin m_phase = 1; m_wait = 0; end
      1: if (b) m_phase = 2;
         else if (m_wait == int'(BT)) begin m_to = 1'b1; m_phase = 0; end
         else m_wait++;
      default: if (!b) m_phase = 0;
    endcase
  endtask

  initial begin
    int k, cnt, left;
    bit found;

    tab[0]  = mk(4'b0100, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 4'b0100, 4'b0000);
    tab[1]  = mk(4'b0000, 16'h0000, 0, 0, 1, 16'hBEEF, 2, 4'b0000, 4'b0000);
    tab[2]  = mk(4'b0000, 16'h0000, 1, 0, 0, 16'hBEEF, 2, 4'b0000, 4'b0000);
    tab[3]  = mk(4'b0000, 16'h0000, 1, 0, 0, 16'hBEEF, 2, 4'b0000, 4'b0000);
    tab[4]  = mk(4'b0000, 16'h0000, 0, 0, 0, 16'hBEEF, 2, 4'b0000, 4'b0000);
    tab[5]  = mk(4'b0001, 16'h1111, 0, 0, 0, 16'hBEEF, 2, 4'b0001, 4'b0000);
    tab[6]  = mk(4'b0001, 16'h2222, 0, 0, 1, 16'h1111, 0, 4'b0001, 4'b0000);
    tab[7]  = mk(4'b0000, 16'h0000, 1, 0, 0, 16'h1111, 0, 4'b0001, 4'b0000);
    tab[8]  = mk(4'b0000, 16'h0000, 0, 0, 0, 16'h1111, 0, 4'b0001, 4'b0000);
    tab[9]  = mk(4'b0000, 16'h0000, 0, 0, 1, 16'h2222, 0, 4'b0000, 4'b0000);
    tab[10] = mk(4'b0000, 16'h0000, 1, 0, 0, 16'h2222, 0, 4'b0000, 4'b0000);
    tab[11] = mk(4'b0000, 16'h0000, 0, 0, 0, 16'h2222, 0, 4'b0000, 4'b0000);
    tab[12] = mk(4'b1000, 16'h3333, 1, 0, 0, 16'h2222, 0, 4'b1000, 4'b0000);
    tab[13] = mk(4'b0000, 16'h0000, 1, 0, 0, 16'h2222, 0, 4'b1000, 4'b0000);
    tab[14] = mk(4'b0000, 16'h0000, 0, 0, 1, 16'h3333, 3, 4'b0000, 4'b0000);
    tab[15] = mk(4'b0000, 16'h0000, 1, 0, 0, 16'h3333, 3, 4'b0000, 4'b0000);
    tab[16] = mk(4'b0000, 16'h0000, 0, 0, 0, 16'h3333, 3, 4'b0000, 4'b0000);
    tab[17] = mk(4'b0001, 16'h4444, 0, 0, 0, 16'h3333, 3, 4'b0001, 4'b0000);
    tab[18] = mk(4'b0010, 16'hAAAA, 0, 0, 1, 16'h4444, 0, 4'b0010, 4'b0000);
    tab[19] = mk(4'b0010, 16'hBBBB, 1, 0, 0, 16'h4444, 0, 4'b0010, 4'b0010);
    tab[20] = mk(4'b0000, 16'h0000, 0, 0, 0, 16'h4444, 0, 4'b0010, 4'b0010);
    tab[21] = mk(4'b0000, 16'h0000, 0, 0, 1, 16'hAAAA, 1, 4'b0000, 4'b0010);
    tab[22] = mk(4'b0000, 16'h0000, 1, 1, 0, 16'hAAAA, 1, 4'b0000, 4'b0000);
    tab[23] = mk(4'b0000, 16'h0000, 0, 0, 0, 16'hAAAA, 1, 4'b0000, 4'b0000);
    tab[24] = mk(4'b0100, 16'h5555, 0, 0, 0, 16'hAAAA, 1, 4'b0100, 4'b0000);
    tab[25] = mk(4'b0100, 16'h6666, 1, 1, 0, 16'hAAAA, 1, 4'b0100, 4'b0100);
    tab[26] = mk(4'b0000, 16'h0000, 0, 0, 1, 16'h5555, 2, 4'b0000, 4'b0100);
    tab[27] = mk(4'b0000, 16'h0000, 1, 1, 0, 16'h5555, 2, 4'b0000, 4'b0000);
    tab[28] = mk(4'b0000, 16'h0000, 0, 0, 0, 16'h5555, 2, 4'b0000, 4'b0000);

    do_reset();
    chk("rst trig", log_trigger, 0);
    chk("rst val", log_val, 0);
    chk("rst id", active_id, 0);
    chk("rst pend", pending, 0);
    chk("rst ovf", overflow, 0);
    chk("rst to", timeout, 0);

    // Vector table: single request, reload on grant, busy in IDLE, overflow, clear vs set.
    for (int i = 0; i < 29; i++) begin
      set_req(tab[i].req, tab[i].val, 0);
      busy_tab = tab[i].busy;
      ovf_clr  = tab[i].clr;
      @(negedge clk);
      chk($sformatf("tab%0d trig", i), log_trigger, tab[i].trig);
      chk($sformatf("tab%0d val", i), log_val, tab[i].lval);
      chk($sformatf("tab%0d id", i), active_id, tab[i].id);
      chk($sformatf("tab%0d pend", i), pending, tab[i].pend);
      chk($sformatf("tab%0d ovf", i), overflow, tab[i].ovf);
      chk($sformatf("tab%0d to", i), timeout, 0);
    end

    // Round-robin fairness with the auto-responding logger.
    do_reset();
    gq_id.delete(); gq_val.delete();
    lg_en = 1; lg_len = 3;
    set_req(4'b1111, 16'h1000, 1);
    @(negedge clk);
    set_req(4'b0000, 16'h0000, 0);
    repeat (40) @(negedge clk);
    chk("rr count", gq_id.size(), 4);
    for (int i = 0; i < 4 && i < gq_id.size(); i++) begin
      chk($sformatf("rr id%0d", i), gq_id[i], i);
      chk($sformatf("rr val%0d", i), gq_val[i], 16'h1000 + 16'(i));
    end
    gq_id.delete(); gq_val.delete();
    for (int p = 0; p < 2; p++) begin
      set_req(4'b1001, 16'h2000 + 16'(p) * 16'h1000, 1);
      @(negedge clk);
      set_req(4'b0000, 16'h0000, 0);
      repeat (20) @(negedge clk);
    end
    chk("rr2 count", gq_id.size(), 4);
    for (int i = 0; i < 4 && i < gq_id.size(); i++)
      chk($sformatf("rr2 id%0d", i), gq_id[i], (i % 2 == 0) ? 0 : 3);
    lg_en = 0;
    repeat (2) @(negedge clk);

    // Timeout: logger never answers.
    do_reset();
    set_req(4'b0011, 16'h7000, 1);
    @(negedge clk);
    chk("to pend", pending, 4'b0011);
    set_req(4'b0000, 16'h0000, 0);
    @(negedge clk);
    chk("to trig", log_trigger, 1);
    chk("to id0", active_id, 0);
    k = 0; found = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (timeout) begin found = 1; k = c; end
    end
    chk("to latency", k, BT + 1);
    chk("to trig low", log_trigger, 0);
    @(negedge clk);
    chk("to next trig", log_trigger, 1);
    chk("to next id", active_id, 1);
    chk("to next val", log_val, 16'h7001);
    chk("to sticky", timeout, 1);

    // Asynchronous reset during WAIT_DONE with two slots still pending.
    do_reset();
    set_req(4'b0111, 16'h8000, 1);
    @(negedge clk);
    set_req(4'b0000, 16'h0000, 0);
    @(negedge clk);
    chk("ar trig", log_trigger, 1);
    chk("ar pend", pending, 4'b0110);
    busy_tab = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar trig0", log_trigger, 0);
    chk("ar val0", log_val, 0);
    chk("ar id0", active_id, 0);
    chk("ar pend0", pending, 0);
    chk("ar ovf0", overflow, 0);
    chk("ar to0", timeout, 0);
    @(negedge clk);
    busy_tab = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (log_trigger) cnt++;
    end
    chk("ar quiet", cnt, 0);
    set_req(4'b0010, 16'h9999, 0);
    @(negedge clk);
    set_req(4'b0000, 16'h0000, 0);
    @(negedge clk);
    chk("ar new trig", log_trigger, 1);
    chk("ar new id", active_id, 1);
    chk("ar new val", log_val, 16'h9999);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    left = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk($sformatf("rnd%0d trig", cyc), log_trigger, m_trig);
      chk($sformatf("rnd%0d val", cyc), log_val, m_lval);
      chk($sformatf("rnd%0d id", cyc), active_id, m_id);
      chk($sformatf("rnd%0d pend", cyc), pending, m_pend);
      chk($sformatf("rnd%0d ovf", cyc), overflow, m_ovf);
      chk($sformatf("rnd%0d to", cyc), timeout, m_to);
      if (m_trig) begin
        if ($urandom_range(0, 9) == 0) begin busy_tab = 1'b0; left = 0; end
        else begin busy_tab = 1'b1; left = int'($urandom_range(1, 5)); end
      end else if (left > 1) begin
        left--;
      end else begin
        left = 0;
        busy_tab = ($urandom_range(0, 19) == 0);
      end
      req = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < int'(N); i++) req_val[i*16 +: 16] = 16'($urandom);
      ovf_clr = ($urandom_range(0, 24) == 0);
      model_step(req, req_val, ovf_clr, busy_tab);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
